// File: rtl/bg_pixel_fetcher.sv
// Background tile fetcher and 16-entry pixel FIFO for the PPU Draw mode.
// Optional window fetching is enabled by defining BG_WINDOW_EN.
module bg_pixel_fetcher #(
    parameter int FIFO_DEPTH  = 16,
    parameter int LINE_PIXELS = 160
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        tick_in,
    input  logic        start_in,
    input  logic [7:0]  LY_in,
    input  logic [7:0]  SCY_in,
    input  logic [7:0]  SCX_in,
    input  logic [7:0]  LCDC_in,
    input  logic [7:0]  BGP_in,
    input  logic [7:0]  WY_in,
    input  logic [7:0]  WX_in,
    output logic [15:0] addr_out,
    output logic        rd_req_out,
    input  logic [7:0]  data_in,
    input  logic        data_valid_in,
    output logic        pixel_valid_out,
    output logic [1:0]  pixel_out,
    output logic [7:0]  x_out,
    output logic        busy_out,
    output logic        line_done_out,
    output logic [2:0]  dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] PUSH_LIMIT = CW'(FIFO_DEPTH - 8);
    localparam logic [7:0]    LAST_X     = 8'(LINE_PIXELS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TILE_REQ  = 3'd1;
    localparam logic [2:0] S_TILE_WAIT = 3'd2;
    localparam logic [2:0] S_LO_REQ    = 3'd3;
    localparam logic [2:0] S_LO_WAIT   = 3'd4;
    localparam logic [2:0] S_HI_REQ    = 3'd5;
    localparam logic [2:0] S_HI_WAIT   = 3'd6;
    localparam logic [2:0] S_PUSH      = 3'd7;

    logic [2:0]    state;
    logic [1:0]    fifo     [FIFO_DEPTH];
    logic [1:0]    fifo_nxt [FIFO_DEPTH];
    logic [CW-1:0] count, count_nxt, base, offs;
    logic [4:0]    fetch_x;
    logic [2:0]    discard;
    logic [7:0]    x_cnt;
    logic [7:0]    tile_idx, lo_q, hi_q, lo_sh, hi_sh;
    logic          end_pend;
    logic          pop_en, push_en, win_switch;
    logic [7:0]    yy, bgp_sh;
    logic          map_sel;
    logic [15:0]   map_addr, data_addr;

    assign dbg_state = state;

`ifdef BG_WINDOW_EN
    logic       win_active;
    logic [7:0] win_line;
    logic       unused_inputs;

    assign unused_inputs = ^{LCDC_in[7], LCDC_in[2:1]};
    assign yy         = win_active ? win_line : SCY_in + LY_in;
    assign map_sel    = win_active ? LCDC_in[6] : LCDC_in[3];
    assign win_switch = LCDC_in[5] && (LY_in >= WY_in) && !win_active && busy_out &&
                        !end_pend && (({1'b0, x_cnt} + 9'd7) == {1'b0, WX_in});

    // The window row counter only advances on lines where the window was drawn.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            win_active <= 1'b0;
            win_line   <= 8'd0;
        end else if (start_in) begin
            win_active <= 1'b0;
            if (LY_in == 8'd0) win_line <= 8'd0;
        end else if (end_pend && win_active) begin
            win_active <= 1'b0;
            win_line   <= win_line + 8'd1;
        end else if (win_switch) begin
            win_active <= 1'b1;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{WY_in, WX_in, LCDC_in[7:5], LCDC_in[2:1]};
    assign yy         = SCY_in + LY_in;
    assign map_sel    = LCDC_in[3];
    assign win_switch = 1'b0;
`endif

    assign map_addr  = (map_sel ? 16'h9C00 : 16'h9800) + {6'b0, yy[7:3], fetch_x};
    assign data_addr = LCDC_in[4] ?
                       16'h8000 + {4'b0, tile_idx, 4'b0} + {12'b0, yy[2:0], 1'b0} :
                       16'h9000 + {{4{tile_idx[7]}}, tile_idx, 4'b0} + {12'b0, yy[2:0], 1'b0};

    assign pop_en  = tick_in && busy_out && !end_pend && (count != '0) && !win_switch;
    assign push_en = (state == S_PUSH) && (count <= PUSH_LIMIT);
    assign bgp_sh  = BGP_in >> {fifo[0], 1'b0};

    // Pop shifts the queue toward entry 0; a push lands right after the survivors.
    always_comb begin
        fifo_nxt  = fifo;
        base      = count - {{(CW-1){1'b0}}, pop_en};
        count_nxt = base + (push_en ? CW'(8) : '0);
        offs      = '0;
        lo_sh     = lo_q;
        hi_sh     = hi_q;
        if (pop_en) begin
            for (int j = 0; j < FIFO_DEPTH - 1; j++) fifo_nxt[j] = fifo[j+1];
            fifo_nxt[FIFO_DEPTH-1] = 2'b00;
        end
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            offs = CW'(j) - base;
            if (push_en && (offs < CW'(8))) begin
                lo_sh       = lo_q << offs[2:0];
                hi_sh       = hi_q << offs[2:0];
                fifo_nxt[j] = {hi_sh[7], lo_sh[7]};
            end
        end
    end

    // VRAM handshake: rd_req_out pulses for one clk with addr_out, which then
    // holds until data_valid_in; data_valid_in is consumed only in a *_WAIT state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= S_IDLE;
            fifo            <= '{default: 2'b00};
            count           <= '0;
            fetch_x         <= 5'd0;
            discard         <= 3'd0;
            x_cnt           <= 8'd0;
            tile_idx        <= 8'd0;
            lo_q            <= 8'd0;
            hi_q            <= 8'd0;
            addr_out        <= 16'd0;
            rd_req_out      <= 1'b0;
            pixel_valid_out <= 1'b0;
            pixel_out       <= 2'b00;
            x_out           <= 8'd0;
            busy_out        <= 1'b0;
            line_done_out   <= 1'b0;
            end_pend        <= 1'b0;
        end else begin
            rd_req_out      <= 1'b0;
            pixel_valid_out <= 1'b0;
            line_done_out   <= 1'b0;
            if (start_in) begin
                state    <= S_TILE_REQ;
                count    <= '0;
                fetch_x  <= SCX_in[7:3];
                discard  <= SCX_in[2:0];
                x_cnt    <= 8'd0;
                busy_out <= 1'b1;
                end_pend <= 1'b0;
            end else begin
                fifo  <= fifo_nxt;
                count <= count_nxt;
                if (end_pend) begin
                    line_done_out <= 1'b1;
                    busy_out      <= 1'b0;
                    end_pend      <= 1'b0;
                end
                case (state)
                    S_TILE_REQ: if (tick_in) begin
                        rd_req_out <= 1'b1;
                        addr_out   <= map_addr;
                        state      <= S_TILE_WAIT;
                    end
                    S_TILE_WAIT: if (data_valid_in) begin
                        tile_idx <= data_in;
                        state    <= S_LO_REQ;
                    end
                    S_LO_REQ: if (tick_in) begin
                        rd_req_out <= 1'b1;
                        addr_out   <= data_addr;
                        state      <= S_LO_WAIT;
                    end
                    S_LO_WAIT: if (data_valid_in) begin
                        lo_q  <= data_in;
                        state <= S_HI_REQ;
                    end
                    S_HI_REQ: if (tick_in) begin
                        rd_req_out <= 1'b1;
                        addr_out   <= data_addr + 16'd1;
                        state      <= S_HI_WAIT;
                    end
                    S_HI_WAIT: if (data_valid_in) begin
                        hi_q  <= data_in;
                        state <= S_PUSH;
                    end
                    S_PUSH: if (push_en) begin
                        fetch_x <= fetch_x + 5'd1;
                        state   <= S_TILE_REQ;
                    end
                    default: ;
                endcase
                if (pop_en) begin
                    if (discard != 3'd0) begin
                        discard <= discard - 3'd1;
                    end else begin
                        pixel_valid_out <= 1'b1;
                        pixel_out       <= LCDC_in[0] ? bgp_sh[1:0] : 2'b00;
                        x_out           <= x_cnt;
                        x_cnt           <= x_cnt + 8'd1;
                        // Last pixel: abandon any fetch now, report done next clk.
                        if (x_cnt == LAST_X) begin
                            state      <= S_IDLE;
                            count      <= '0;
                            rd_req_out <= 1'b0;
                            end_pend   <= 1'b1;
                        end
                    end
                end
                if (win_switch) begin
                    state      <= S_TILE_REQ;
                    count      <= '0;
                    fetch_x    <= 5'd0;
                    discard    <= 3'd0;
                    rd_req_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bg_pixel_fetcher.sv
// Directed bench for bg_pixel_fetcher: VRAM responder, per-screen-pixel reference
// model feeding an expected queue, and a per-cycle compare process.
module tb_bg_pixel_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in, tick_in, start_in;
    logic [7:0]  LY_in, SCY_in, SCX_in, LCDC_in, BGP_in, WY_in, WX_in, data_in;
    logic        data_valid_in;
    logic [15:0] addr_out;
    logic        rd_req_out, pixel_valid_out, busy_out, line_done_out;
    logic [1:0]  pixel_out;
    logic [7:0]  x_out;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int lat = 3;
    int tick_div = 1;
    int pix_cnt, done_cnt, req_cnt;
    logic [1:0]  first_shade;
    logic [7:0]  first_x;
    logic        last_was_159;
    logic [7:0]  vram [0:65535];
    logic [9:0]  exp_q [$];
    logic [15:0] req_log [$];

    bg_pixel_fetcher dut (
        .clk_in(clk_in), .rst_in(rst_in), .tick_in(tick_in), .start_in(start_in),
        .LY_in(LY_in), .SCY_in(SCY_in), .SCX_in(SCX_in), .LCDC_in(LCDC_in),
        .BGP_in(BGP_in), .WY_in(WY_in), .WX_in(WX_in), .addr_out(addr_out),
        .rd_req_out(rd_req_out), .data_in(data_in), .data_valid_in(data_valid_in),
        .pixel_valid_out(pixel_valid_out), .pixel_out(pixel_out), .x_out(x_out),
        .busy_out(busy_out), .line_done_out(line_done_out), .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Tick strobe driver
    initial begin
        int ph;
        ph = 0;
        tick_in = 1'b0;
        forever begin
            @(negedge clk_in);
            ph++;
            tick_in = ((ph % tick_div) == 0);
        end
    end

    // VRAM responder: answers each request after lat clks
    initial begin
        logic [15:0] a;
        data_valid_in = 1'b0;
        data_in = 8'h00;
        forever begin
            @(negedge clk_in);
            data_valid_in = 1'b0;
            if (rd_req_out) begin
                a = addr_out;
                req_log.push_back(a);
                repeat (lat - 1) @(negedge clk_in);
                data_in = vram[a];
                data_valid_in = 1'b1;
            end
        end
    end

    // Scoreboard / compare process
    initial begin
        logic [9:0] e;
        last_was_159 = 1'b0;
        forever begin
            @(negedge clk_in);
            if (rd_req_out) req_cnt++;
            if (pixel_valid_out) begin
                pix_cnt++;
                if (pix_cnt == 1) begin
                    first_shade = pixel_out;
                    first_x = x_out;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pixel_extra: got x=%0d shade=%0d, expected no pixel", x_out, pixel_out);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel_x", 32'(x_out), 32'(e[7:0]));
                    check("pixel_shade", 32'(pixel_out), 32'(e[9:8]));
                end
            end
            if (line_done_out) begin
                done_cnt++;
                check("done_after_last_pixel", 32'(last_was_159), 32'd1);
            end
            last_was_159 = pixel_valid_out && (x_out == 8'd159);
        end
    end

    // Reference: for every screen pixel, look up its tile, row and bit directly.
    task automatic build_expected(input logic [7:0] scx, scy, ly, lcdc, bgp);
        logic [7:0]  yy, bgx, idx;
        logic [15:0] ma, da;
        logic [1:0]  c;
        int          b;
        yy = scy + ly;
        for (int x = 0; x < 160; x++) begin
            bgx = scx + 8'(x);
            ma  = (lcdc[3] ? 16'h9C00 : 16'h9800) + 16'(yy / 8) * 16'd32 + 16'(bgx / 8);
            idx = vram[ma];
            if (lcdc[4]) da = 16'h8000 + 16'(idx) * 16'd16 + 16'(yy % 8) * 16'd2;
            else         da = 16'(32'h9000 + int'($signed(idx)) * 16 + int'(yy % 8) * 2);
            b = 7 - int'(bgx % 8);
            c = {vram[da + 16'd1][b], vram[da][b]};
            exp_q.push_back({(lcdc[0] ? bgp[2*c +: 2] : 2'b00), 8'(x)});
        end
    endtask

    task automatic prep_line(input logic [7:0] scx, scy, ly, lcdc, bgp);
        SCX_in = scx; SCY_in = scy; LY_in = ly; LCDC_in = lcdc; BGP_in = bgp;
        exp_q.delete();
        req_log.delete();
        pix_cnt = 0; done_cnt = 0; req_cnt = 0;
        build_expected(scx, scy, ly, lcdc, bgp);
    endtask

    task automatic run_line(input string tag);
        int guard;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < 20000) begin
            @(posedge clk_in);
            guard++;
        end
        check({tag, "_line_done_in_time"}, 32'(guard < 20000), 32'd1);
        repeat (5) @(negedge clk_in);
        check({tag, "_pixel_count"}, 32'(pix_cnt), 32'd160);
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_low"}, 32'(busy_out), 32'd0);
    endtask

    task automatic fill_uniform();
        for (int a = 32'h8000; a < 32'h9800; a++) vram[a] = a[0] ? 8'h00 : 8'hFF;
        for (int a = 32'h9800; a < 32'hA000; a++) vram[a] = 8'h01;
    endtask

    task automatic fill_random();
        for (int a = 32'h8000; a < 32'hA000; a++) vram[a] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, 32'(addr_out), 32'd0);
        check({tag, "_rd_req"}, 32'(rd_req_out), 32'd0);
        check({tag, "_pixel_valid"}, 32'(pixel_valid_out), 32'd0);
        check({tag, "_pixel"}, 32'(pixel_out), 32'd0);
        check({tag, "_x"}, 32'(x_out), 32'd0);
        check({tag, "_busy"}, 32'(busy_out), 32'd0);
        check({tag, "_line_done"}, 32'(line_done_out), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // Directed stimulus
    initial begin
        int guard, snap;
        rst_in = 1'b0; start_in = 1'b0;
        LY_in = 0; SCY_in = 0; SCX_in = 0; LCDC_in = 0; BGP_in = 0; WY_in = 0; WX_in = 0;
        pix_cnt = 0; done_cnt = 0; req_cnt = 0;
        repeat (3) @(negedge clk_in);
        check_idle_outputs("reset");
        rst_in = 1'b1;

        // Uniform tiles: colour 1 everywhere, BGP 0xE4 maps it to shade 1
        fill_uniform();
        prep_line(8'h00, 8'h00, 8'h00, 8'h91, 8'hE4);
        check("model_uniform_first", 32'(exp_q[0]), 32'({2'd1, 8'd0}));
        check("model_uniform_last", 32'(exp_q[159]), 32'({2'd1, 8'd159}));
        run_line("uniform");
        check("uniform_map_addr", 32'(req_log[0]), 32'h9800);
        check("uniform_lo_addr", 32'(req_log[1]), 32'h8010);
        check("uniform_hi_addr", 32'(req_log[2]), 32'h8011);

        // Fine scroll discard: screen pixel 0 is tile column bit 3 (colour 3)
        fill_random();
        vram[16'h9800] = 8'h02; vram[16'h8020] = 8'h10; vram[16'h8021] = 8'h10;
        prep_line(8'h03, 8'h00, 8'h00, 8'h91, 8'hE4);
        check("model_scx3_first", 32'(exp_q[0]), 32'({2'd3, 8'd0}));
        run_line("scx3");
        check("scx3_first_x", 32'(first_x), 32'd0);
        check("scx3_first_shade", 32'(first_shade), 32'd3);

        // Signed tile-data addressing, LY = 2
        fill_random();
        vram[16'h9800] = 8'h80; vram[16'h9801] = 8'h7F;
        tick_div = 2; lat = 2;
        prep_line(8'h00, 8'h00, 8'h02, 8'h81, 8'h1B);
        run_line("signed");
        check("signed_map0", 32'(req_log[0]), 32'h9800);
        check("signed_lo_80", 32'(req_log[1]), 32'h8804);
        check("signed_map1", 32'(req_log[3]), 32'h9801);
        check("signed_lo_7f", 32'(req_log[4]), 32'h97F4);

        // Map column wrap from 31 to 0
        lat = 1;
        prep_line(8'hF8, 8'h00, 8'h00, 8'h91, 8'hE4);
        run_line("wrap");
        check("wrap_map_col31", 32'(req_log[0]), 32'h981F);
        check("wrap_map_col0", 32'(req_log[3]), 32'h9800);

        // High map, non-zero row and scroll: yy = 0x34, column 4, discard 5
        tick_div = 1; lat = 3;
        prep_line(8'h25, 8'h13, 8'h21, 8'h99, 8'h6C);
        run_line("map9c");
        check("map9c_first_map", 32'(req_log[0]), 32'h9CC4);

        // Reset while waiting on the low byte; its late data must be ignored
        lat = 8;
        exp_q.delete(); pix_cnt = 0; done_cnt = 0;
        SCX_in = 8'h00; SCY_in = 8'h00; LY_in = 8'h00; LCDC_in = 8'h91;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        guard = 0;
        while (dbg_state != 3'd4 && guard < 200) begin
            @(posedge clk_in); #1;
            guard++;
        end
        check("midfetch_reached_lo_wait", 32'(dbg_state), 32'd4);
        @(negedge clk_in); rst_in = 1'b0; #1;
        check_idle_outputs("midfetch_reset");
        @(negedge clk_in); rst_in = 1'b1;
        snap = req_cnt;
        repeat (20) @(negedge clk_in);
        check("late_dv_state", 32'(dbg_state), 32'd0);
        check("late_dv_busy", 32'(busy_out), 32'd0);
        check("late_dv_no_request", 32'(req_cnt), 32'(snap));
        check("late_dv_no_pixels", 32'(pix_cnt), 32'd0);

        // BG disabled: every shade is 0
        lat = 2;
        fill_random();
        prep_line(8'h05, 8'h07, 8'h09, 8'h90, 8'hE4);
        check("model_bg_off", 32'(exp_q[37][9:8]), 32'd0);
        run_line("bg_off");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bg_pixel_fetcher.md
Name: bg_pixel_fetcher

Overview:
- Background tile fetcher plus 16-entry pixel FIFO, run during PPU Draw mode.
- Fetches tile-map and tile-data bytes from VRAM over a request/valid handshake.
- Decodes each fetch into 2-bit colour indices, applies SCX fine-scroll discard and the BGP palette, and emits one shaded pixel per T-cycle tick.
- Pulses line-done after 160 pixels so the PPU leaves Draw.

Parameters:
FIFO_DEPTH, 16, pixel FIFO entries (must be >= 16)
LINE_PIXELS, 160, visible pixels per scanline

Ports:
clk_in  input  1  system clock; single clock domain
rst_in  input  1  asynchronous, active-low reset
tick_in  input  1  T-cycle strobe, one clk_in wide
start_in  input  1  pulse: begin a scanline (PPU enters Draw)
LY_in  input  8  current scanline
SCY_in  input  8  scroll Y
SCX_in  input  8  scroll X
LCDC_in  input  8  bit0 BG enable, bit3 BG map select, bit4 tile-data select, bit5 window enable, bit6 window map select
BGP_in  input  8  background palette
WY_in  input  8  window Y (used only with the optional feature)
WX_in  input  8  window X (used only with the optional feature)
addr_out  output  16  VRAM read address
rd_req_out  output  1  read request, one clk pulse
data_in  input  8  read data
data_valid_in  input  1  data_in valid for the outstanding request
pixel_valid_out  output  1  pixel_out valid this clk
pixel_out  output  2  shade (BGP-mapped)
x_out  output  8  screen X of pixel_out, 0..159
busy_out  output  1  high from start_in until line done
line_done_out  output  1  one-clk pulse after the last pixel is emitted

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; fetch_x = 0; discard count = 0.
- States:
  - IDLE
  - TILE_REQ -> TILE_WAIT
  - LO_REQ -> LO_WAIT
  - HI_REQ -> HI_WAIT
  - PUSH
- Transitions:
  - start_in in any state flushes the FIFO, sets fetch_x = SCX[7:3], discard = SCX[2:0] and X = 0, then moves to TILE_REQ.
  - A *_REQ state, on tick_in, drives rd_req_out = 1 for that clk and latches addr_out; addr_out stays stable until data_valid_in.
  - A *_WAIT state advances on data_valid_in (any clk, not gated by tick).
  - data_valid_in outside a WAIT state is ignored.
- Address arithmetic:
  - yy = (SCY + LY) mod 256.
  - Map address = (LCDC[3] ? 0x9C00 : 0x9800) + yy[7:3]*32 + fetch_x[4:0].
  - Tile data, LCDC[4] = 1: 0x8000 + idx*16 + yy[2:0]*2.
  - Tile data, LCDC[4] = 0: 0x9000 + signed(idx)*16 + yy[2:0]*2.
  - High byte address = low byte address + 1.
- PUSH:
  - Waits until FIFO count <= FIFO_DEPTH-8.
  - Then pushes 8 entries in one clk. Entry i (i = 0 leftmost) = {hi[7-i], lo[7-i]}.
  - fetch_x increments mod 32 (map column wraps), then state returns to TILE_REQ.
- Pop:
  - On tick_in with FIFO count > 0, one entry is popped.
  - While discard > 0, the popped entry is dropped and discard decrements; no pixel, X unchanged.
  - Otherwise pixel_valid_out = 1 and pixel_out = LCDC[0] ? BGP[2c+1:2c] : 2'b00.
  - x_out = X, then X increments.
- Push and pop in the same clk are legal; count' = count + 8 - 1. The FIFO never overflows.
- Pixel latency: first pixel_valid_out no earlier than the first tick after the first PUSH completes; outputs are registered.
- Line end:
  - When the pixel with X = 159 is emitted, line_done_out pulses on the next clk.
  - busy_out falls, the FIFO is flushed and the state returns to IDLE.
  - Any in-flight request is abandoned; its later data_valid_in is ignored.
- Asynchronous reset mid-fetch returns the block to the full reset state immediately.

Optional Feature:
- Macro: BG_WINDOW_EN.
- When defined:
  - With LCDC[5] = 1 and LY >= WY, the fetcher switches to the window once X + 7 == WX.
  - The switch flushes the FIFO, sets fetch_x = 0 and discard = 0, and uses the LCDC[6] map.
  - Row source is an internal window line counter; it increments at line end if the window was drawn and clears on start_in when LY == 0.
- When undefined: WY_in and WX_in are unused and the window is never fetched.

Test Plan:
1. Reset -> all outputs 0. start_in with SCX = 0, SCY = 0, LY = 0, LCDC = 0x91 -> first rd_req_out has addr_out 0x9800; tile idx 0x01 -> low-byte address 0x8010, high-byte address 0x8011.
2. lo = 0xFF, hi = 0x00, BGP = 0xE4, constant latency -> 160 pixels of shade 1, x_out 0..159 in order; exactly one line_done_out pulse.
3. SCX = 0x03 -> first 3 popped entries dropped; first pixel_valid_out has x_out = 0 and the colour of tile column bit 3.
4. LCDC[4] = 0, idx 0x80, LY = 2 -> low-byte address 0x8804. idx 0x7F -> 0x97F4.
5. SCX = 0xF8 -> first map read at column 31 (0x981F), second at column 0 (0x9800).
6. rst_in low during LO_WAIT -> outputs cleared immediately; a late data_valid_in is ignored. LCDC[0] = 0 -> every pixel_out = 0.
